// File: rtl/div_if.sv
// Divider request/response bundle between EX (master) and div_unit (slave).
`timescale 1ns/1ps
interface div_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} for HI/LO writeback.
`timescale 1ns/1ps
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     rem_q;
    logic [DATA_W-1:0]     quo_q;
    logic [DATA_W-1:0]     dvs_q;
    logic                  signed_q;
    logic                  sign1_q;
    logic                  sign2_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;

    logic                  start_ok;
    logic [DATA_W-1:0]     op1_mag;
    logic [DATA_W-1:0]     op2_mag;
    logic [DATA_W:0]       shifted;
    logic                  no_borrow;
    logic [DATA_W-1:0]     step_rem;
    logic [DATA_W-1:0]     step_quo;
    logic [DATA_W-1:0]     fin_rem;
    logic [DATA_W-1:0]     fin_quo;
    logic                  last_iter;

    // Operand magnitudes; |0x80000000| stays 0x80000000 and is read as unsigned 2^31.
    always_comb begin
        start_ok = bus.start_i && !bus.annul_i;
        op1_mag  = bus.opdata1_i;
        op2_mag  = bus.opdata2_i;
        if (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) op1_mag = DATA_W'(0) - bus.opdata1_i;
        if (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) op2_mag = DATA_W'(0) - bus.opdata2_i;
    end

    // One restoring step: shift {rem,dividend} left, trial-subtract divisor from the top half.
    always_comb begin
        shifted   = {rem_q, quo_q[DATA_W-1]};
        no_borrow = (shifted >= {1'b0, dvs_q});
        step_rem  = no_borrow ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
        step_quo  = {quo_q[DATA_W-2:0], no_borrow};
        last_iter = (cnt == CNT_W'(DATA_W - 1));
        fin_quo   = (signed_q && (sign1_q ^ sign2_q)) ? (DATA_W'(0) - step_quo) : step_quo;
        fin_rem   = (signed_q && sign1_q) ? (DATA_W'(0) - step_rem) : step_rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    if (start_ok) begin
                        signed_q <= bus.signed_div_i;
                        sign1_q  <= bus.opdata1_i[DATA_W-1];
                        sign2_q  <= bus.opdata2_i[DATA_W-1];
                        cnt      <= '0;
                        if (bus.opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            rem_q <= '0;
                            quo_q <= op1_mag;
                            dvs_q <= op2_mag;
                            state <= S_ON;
                        end
                    end
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        state    <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            state    <= S_END;
                            result_q <= {fin_rem, fin_quo};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                S_BYZERO: begin
                    // Architecturally undefined in MIPS; this core returns zero.
                    state    <= bus.annul_i ? S_FREE : S_END;
                    result_q <= '0;
                    ready_q  <= !bus.annul_i;
                end
                S_END: begin
                    if (!bus.start_i) begin
                        state    <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end

    // Stall drops in END so EX advances in the cycle ready_o is high.
    assign bus.stallreq_o = (state == S_FREE && start_ok) || (state == S_ON) || (state == S_BYZERO);
    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus hand-written annul/reset sequences.
`timescale 1ns/1ps
module tb_div_unit;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Full transaction: start, count edges to ready, verify result, hold, release.
    task automatic run_div(input vec_t v);
        int   edges;
        int   stalls;
        logic done;
        bus.start_i      = 1'b1;
        bus.signed_div_i = v.sgn;
        bus.opdata1_i    = v.a;
        bus.opdata2_i    = v.b;
        #1;
        stalls = bus.stallreq_o ? 1 : 0;
        edges  = 0;
        done   = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~v.sgn;
            end
            if (bus.ready_o) done = 1'b1;
            else if (bus.stallreq_o) stalls++;
        end
        check({v.name, "_latency"}, 64'(edges), 64'(v.lat));
        check({v.name, "_stall_cycles"}, 64'(stalls), 64'(v.lat));
        check({v.name, "_result"}, bus.result_o, {v.r, v.q});
        check({v.name, "_stall_in_end"}, 64'(bus.stallreq_o), 64'(0));
        @(posedge clk); #1;
        check({v.name, "_hold"}, {63'(bus.ready_o), 1'b0} ^ 64'(0) | 64'(0),
              {63'(1), 1'b0});
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check({v.name, "_release"}, {bus.result_o[62:0], bus.ready_o}, 64'(0));
    endtask

    vec_t vecs[12];
    vec_t v;
    int   edges;
    int   rises;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0]  = '{"divu_100_7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{"div_m100_7",     1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   33};
        vecs[2]  = '{"div_100_m7",     1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          33};
        vecs[3]  = '{"div_m100_m7",    1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   33};
        vecs[4]  = '{"divu_big_7",     1'b0, 32'hFFFFFF9C,   32'd7,          32'h24924916,   32'd2,          33};
        vecs[5]  = '{"div_by_zero",    1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          2};
        vecs[6]  = '{"divu_by_zero",   1'b0, 32'hFFFFFFFF,   32'd0,          32'd0,          32'd0,          2};
        vecs[7]  = '{"div_overflow",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33};
        vecs[8]  = '{"divu_max_1",     1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33};
        vecs[9]  = '{"divu_3_9",       1'b0, 32'd3,          32'd9,          32'd0,          32'd3,          33};
        vecs[10] = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
        vecs[11] = '{"divu_msb_msb",   1'b0, 32'h80000000,   32'h80000000,   32'd1,          32'd0,          33};

        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", bus.result_o, 64'(0));
        check("reset_ready", 64'(bus.ready_o), 64'(0));
        check("reset_stall", 64'(bus.stallreq_o), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_div(vecs[i]);

        // annul while FREE blocks the start
        bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd3;
        #1;
        check("annul_free_stall", 64'(bus.stallreq_o), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("annul_free_idle", {62'(0), bus.stallreq_o, bus.ready_o}, 64'(0));
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        @(posedge clk); #1;

        // annul mid-ON: flush, nothing presented, then a clean DIVU 9/3
        bus.start_i = 1'b1; bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        check("annul_on_busy", 64'(bus.stallreq_o), 64'(1));
        bus.annul_i = 1'b1; bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        check("annul_on_flushed", {bus.result_o[61:0], bus.stallreq_o, bus.ready_o}, 64'(0));
        rises = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready_o) rises++;
        end
        check("annul_on_no_ready", 64'(rises), 64'(0));
        v = '{"divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33};
        run_div(v);

        // annul in BYZERO drops the request
        bus.start_i = 1'b1; bus.signed_div_i = 1'b1; bus.opdata1_i = 32'd7; bus.opdata2_i = 32'd0;
        @(posedge clk); #1;
        check("byzero_stall", 64'(bus.stallreq_o), 64'(1));
        bus.annul_i = 1'b1; bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        check("annul_byzero", {62'(0), bus.stallreq_o, bus.ready_o}, 64'(0));
        @(posedge clk); #1;
        check("annul_byzero_later", 64'(bus.ready_o), 64'(0));

        // annul in END is ignored
        bus.start_i = 1'b1; bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        edges = 0;
        while (!bus.ready_o && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("end_latency", 64'(edges), 64'(33));
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_end_ready", 64'(bus.ready_o), 64'(1));
        check("annul_end_result", bus.result_o, {32'd2, 32'd14});
        bus.annul_i = 1'b0; bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("end_exit", 64'(bus.ready_o), 64'(0));

        // async reset mid-ON, then relaunch with start held
        bus.start_i = 1'b1; bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_ready", 64'(bus.ready_o), 64'(0));
        check("async_rst_result", bus.result_o, 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        edges = 0;
        while (!bus.ready_o && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("relaunch_latency", 64'(edges), 64'(33));
        check("relaunch_result", bus.result_o, {32'd2, 32'd14});
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("relaunch_release", 64'(bus.ready_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
